// File: rtl/lsb_mem_port.sv
// lsb_mem_port
// Requester-side sequencer between the load/store buffer and mem_ctrl.
// A single LSB load or store of 1, 2 or 4 bytes becomes a back-to-back
// series of byte transactions on the byte-wide memory port. Load bytes
// are assembled little-endian and sign/zero-extended; store bytes are
// serialised little-endian. Stores into the IO window stall while the
// UART TX buffer is full.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   rdy_in                global ready; low blocks issue and acceptance
//   req_valid/req_ready   LSB request handshake (ready only in IDLE)
//   req_wr, req_size,     request kind, size (0 byte, 1 half, 2/3 word),
//   req_signed, req_addr, sign-extend flag, byte address, store data
//   req_wdata
//   flush                 misprediction clear (aborts loads only)
//   resp_valid/resp_rdata one-cycle completion pulse and load result
//   mem_need, mem_addr,   byte request to mem_ctrl (granted same cycle)
//   mem_wr, mem_wdata
//   mem_byte              read byte, one cycle after the read is issued
//   io_buffer_full        UART TX buffer full
module lsb_mem_port #(
    parameter logic [31:0] IO_ADDR = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        mem_need,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_byte,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        wr_q, wr_d;
    logic [2:0]  i_q, i_d;       // issue pointer
    logic [2:0]  c_q, c_d;       // capture pointer
    logic        p_q, p_d;       // a read was issued last cycle
    logic [31:0] asm_q, asm_d;   // load assembly register
    logic [31:0] rdata_q, rdata_d;

    logic [2:0]  n_s;
    logic        io_hit_s;
    logic        stall_s;
    logic        need_s;
    logic        accept_s;
    logic [31:0] asm_cap_s;

    // Number of bytes moved for a size code; size 3 behaves as a word.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'd0:    n = 3'd1;
            2'd1:    n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Sign- or zero-extend the assembled load bytes to 32 bits.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        logic [31:0] r;
        case (size)
            2'd0:    r = {{24{sgn & raw[7]}}, raw[7:0]};
            2'd1:    r = {{16{sgn & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Replace byte lane idx of word w with b.
    function automatic logic [31:0] put_byte(input logic [31:0] w,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Select byte lane idx of word w.
    function automatic logic [7:0] get_byte(input logic [31:0] w,
                                            input logic [1:0]  idx);
        logic [7:0] r;
        case (idx)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            default: r = w[31:24];
        endcase
        return r;
    endfunction

    assign n_s       = size_to_n(size_q);
    // The IO window is decoded on the latched start address only.
    assign io_hit_s  = (addr_q[17:16] == IO_ADDR[17:16]);
    assign stall_s   = (state_q == STORE) && io_hit_s && io_buffer_full;
    assign need_s    = ((state_q == LOAD) || (state_q == STORE)) &&
                       (i_q < n_s) && rdy_in && !stall_s;
    assign accept_s  = (state_q == IDLE) && req_valid && rdy_in && !flush;
    // Assembly value including the byte being captured this cycle, so the
    // final extension sees all N bytes on the edge that completes the load.
    assign asm_cap_s = put_byte(asm_q, c_q[1:0], mem_byte);

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        wr_d    = wr_q;
        i_d     = i_q;
        c_d     = c_q;
        p_d     = p_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                p_d = 1'b0;
                if (accept_s) begin
                    state_d = req_wr ? STORE : LOAD;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    wr_d    = req_wr;
                    i_d     = 3'd0;
                    c_d     = 3'd0;
                    asm_d   = 32'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (flush) begin
                    // Abort: drop any pending capture, no response.
                    state_d = IDLE;
                    p_d     = 1'b0;
                end else begin
                    i_d = need_s ? (i_q + 3'd1) : i_q;
                    p_d = need_s;
                    // Captures are not gated by rdy_in: the byte is
                    // already on the bus.
                    if (p_q) begin
                        asm_d = asm_cap_s;
                        c_d   = c_q + 3'd1;
                        if ((c_q + 3'd1) == n_s) begin
                            state_d = DONE;
                            rdata_d = extend_load(asm_cap_s, size_q, sgn_q);
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            STORE: begin
                // Flush is ignored: a committed store always finishes.
                if (need_s) begin
                    i_d     = i_q + 3'd1;
                    state_d = ((i_q + 3'd1) == n_s) ? DONE : STORE;
                end else begin
                    state_d = STORE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            sgn_q   <= 1'b0;
            wr_q    <= 1'b0;
            i_q     <= 3'd0;
            c_q     <= 3'd0;
            p_q     <= 1'b0;
            asm_q   <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            wr_q    <= wr_d;
            i_q     <= i_d;
            c_q     <= c_d;
            p_q     <= p_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    // A flush seen during a load's DONE cycle suppresses its response.
    assign resp_valid = (state_q == DONE) && !(!wr_q && flush);
    // Stores report zero data; otherwise the last load result is held.
    assign resp_rdata = ((state_q == DONE) && wr_q) ? 32'd0 : rdata_q;
    assign mem_need   = need_s;
    assign mem_addr   = addr_q + {29'd0, i_q};
    assign mem_wr     = (state_q == STORE) && need_s;
    assign mem_wdata  = get_byte(wdata_q, i_q[1:0]);

endmodule

// File: tb/tb_lsb_mem_port.sv
module tb_lsb_mem_port;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_need;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_byte;
    logic        io_buffer_full;

    lsb_mem_port #(.IO_ADDR(32'h0003_0000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .mem_need(mem_need), .mem_addr(mem_addr),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_byte(mem_byte),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  data;
    } acc_t;

    acc_t        exp_acc[$];
    logic [31:0] exp_resp[$];
    logic [7:0]  ref_mem [bit [31:0]];
    logic [7:0]  mem [0:4095];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int iss_cnt = 0;
    int first_iss = -1;
    int last_iss  = -1;
    int resp_cnt  = 0;
    int resp_cyc  = 0;
    int resp_base = 0;
    int acc_cyc   = 0;
    logic [31:0] last_rdata = 32'd0;
    acc_t        cur;
    logic [31:0] er;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] midx(input logic [31:0] a);
        return {a[17:16], a[9:0]};
    endfunction

    function automatic logic [7:0] init_byte(input int k);
        logic [7:0] b;
        case (k)
            0: b = 8'h78;
            1: b = 8'h56;
            2: b = 8'h34;
            3: b = 8'h12;
            4: b = 8'h80;
            6: b = 8'h01;
            7: b = 8'h80;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    function automatic int size_n(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    // Little-endian value of n bytes, then two's-complement reinterpretation.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic sg);
        int     n;
        longint v;
        n = size_n(s);
        v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(rd_ref(a + k)) << (8 * k));
        if (sg && (v >= (64'sd1 <<< (8 * n - 1)))) v = v - (64'sd1 <<< (8 * n));
        return v[31:0];
    endfunction

    // Byte memory behind mem_ctrl: 1-cycle read latency, reloaded on reset.
    always @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < 4096; k++) mem[k] <= init_byte(k);
            mem_byte <= 8'h5A;
        end else if (mem_need && !mem_wr) begin
            mem_byte <= mem[midx(mem_addr)];
        end else begin
            if (mem_need && mem_wr) mem[midx(mem_addr)] <= mem_wdata;
            mem_byte <= 8'h5A;
        end
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    // Per-cycle compare against the expected access and response queues.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (mem_need) begin
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
                iss_cnt++;
                if (exp_acc.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got addr 0x%08h, no access expected", mem_addr);
                end else begin
                    cur = exp_acc.pop_front();
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_wr", {31'd0, mem_wr}, {31'd0, cur.wr});
                    if (cur.wr) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, cur.data});
                end
            end
            if (resp_valid) begin
                resp_cnt++;
                resp_cyc   = cyc;
                last_rdata = resp_rdata;
                if (exp_resp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got 0x%08h, no response expected", resp_rdata);
                end else begin
                    er = exp_resp.pop_front();
                    check("resp_rdata", resp_rdata, er);
                end
            end
        end
    end

    // Queue the model's expectations, then present the request until accepted.
    task automatic start_req(input logic wr, input logic [1:0] s, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int n_iss, input logic want_resp);
        int   n;
        acc_t x;
        logic [31:0] v;
        n = size_n(s);
        for (int k = 0; k < n; k++) begin
            if (k < n_iss) begin
                x.addr = a + k;
                x.wr   = wr;
                x.data = 8'((wd >> (8 * k)) & 32'hFF);
                exp_acc.push_back(x);
            end
        end
        if (wr) begin
            for (int k = 0; k < n; k++) if (k < n_iss) ref_mem[a + k] = 8'((wd >> (8 * k)) & 32'hFF);
            v = 32'd0;
        end else begin
            v = model_load(a, s, sg);
        end
        if (want_resp) exp_resp.push_back(v);
        iss_cnt   = 0;
        first_iss = -1;
        last_iss  = -1;
        resp_base = resp_cnt;
        for (int t = 0; t < 20 && !req_ready; t++) begin
            @(posedge clk_in);
            #1;
        end
        check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_size   = s;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk_in);
        #1;
        req_valid = 1'b0;
        acc_cyc   = cyc;
    endtask

    // Wait (bounded) for the response; returns cycles from accept to resp_valid.
    task automatic wait_resp(output int lat);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk_in);
            #1;
            seen = (resp_cnt != resp_base);
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: got no resp_valid, required one within 30 cycles");
        end
        lat = resp_cyc - acc_cyc;
        @(posedge clk_in);
        #1;
        check("req_ready_after_done", {31'd0, req_ready}, 32'd1);
        check("acc_queue_drained", exp_acc.size(), 32'd0);
    endtask

    int lat;

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_size = 2'd0;
        req_signed = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        flush = 1'b0;
        io_buffer_full = 1'b0;
        for (int k = 0; k < 8; k++) ref_mem[32'h1000 + k] = init_byte(k);
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_need", {31'd0, mem_need}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // Word load 0x1000
        start_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 4, 1'b1);
        wait_resp(lat);
        check("word_load_data", last_rdata, 32'h1234_5678);
        check("word_load_latency", lat, 32'd5);
        check("word_load_first_issue", first_iss - acc_cyc, 32'd0);
        check("word_load_last_issue", last_iss - acc_cyc, 32'd3);

        // Signed byte 0x80, unsigned half 0x8001
        start_req(1'b0, 2'd0, 1'b1, 32'h1004, 32'h0, 4, 1'b1);
        wait_resp(lat);
        check("sbyte_data", last_rdata, 32'hFFFF_FF80);
        check("sbyte_latency", lat, 32'd2);
        start_req(1'b0, 2'd1, 1'b0, 32'h1006, 32'h0, 4, 1'b1);
        wait_resp(lat);
        check("uhalf_data", last_rdata, 32'h0000_8001);
        check("uhalf_latency", lat, 32'd3);

        // Model-only variants: signed half, unsigned byte, misaligned size-3 load
        start_req(1'b0, 2'd1, 1'b1, 32'h1006, 32'h0, 4, 1'b1);
        wait_resp(lat);
        start_req(1'b0, 2'd0, 1'b0, 32'h1004, 32'h0, 4, 1'b1);
        wait_resp(lat);
        start_req(1'b0, 2'd3, 1'b1, 32'h1001, 32'h0, 4, 1'b1);
        wait_resp(lat);
        check("misaligned_word_data", last_rdata, 32'h8012_3456);

        // Half store 0xBEEF to 0x1001, then read back the word
        start_req(1'b1, 2'd1, 1'b0, 32'h1001, 32'hDEAD_BEEF, 4, 1'b1);
        wait_resp(lat);
        check("hstore_latency", lat, 32'd2);
        check("hstore_issue_cnt", iss_cnt, 32'd2);
        start_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 4, 1'b1);
        wait_resp(lat);
        check("readback_word", last_rdata, 32'h12BE_EF78);

        // Word store restores the original pattern
        start_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h1234_5678, 4, 1'b1);
        wait_resp(lat);
        check("wstore_latency", lat, 32'd4);

        // IO store with the UART buffer full for 3 cycles
        io_buffer_full = 1'b1;
        start_req(1'b1, 2'd0, 1'b0, 32'h0003_0000, 32'h0000_0041, 4, 1'b1);
        repeat (3) @(posedge clk_in);
        #1;
        io_buffer_full = 1'b0;
        wait_resp(lat);
        check("io_first_issue", first_iss - acc_cyc, 32'd3);
        check("io_latency", lat, 32'd4);

        // Flush in the 2nd issue cycle of a word load
        start_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 2, 1'b0);
        @(posedge clk_in);
        #1;
        flush = 1'b1;
        @(posedge clk_in);
        #1;
        flush = 1'b0;
        check("flush_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (6) @(negedge clk_in);
        #1;
        check("flush_issue_cnt", iss_cnt, 32'd2);
        check("flush_no_resp", resp_cnt - resp_base, 32'd0);

        // rdy_in low for 2 cycles after the first issue
        start_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 4, 1'b1);
        @(posedge clk_in);
        #1;
        rdy_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rdy_in = 1'b1;
        wait_resp(lat);
        check("rdy_stall_data", last_rdata, 32'h1234_5678);
        check("rdy_stall_latency", lat, 32'd7);

        // Reset in the middle of a word load
        start_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'hAABB_CCDD, 2, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_resp_rdata", resp_rdata, 32'd0);
        check("midrst_mem_need", {31'd0, mem_need}, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("midrst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("midrst_acc_queue", exp_acc.size(), 32'd0);
        repeat (3) @(negedge clk_in);
        #1;
        check("midrst_idle_need", {31'd0, mem_need}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
